branch_resolution_unit: RTL and testbench

Tracks every conditional branch between its prediction in IF and its resolution in EX, and closes the loop on the predictor. IF pushes a prediction record (direction, predicted target, fall-through PC, GBHR snapshot) into a small in-order queue. When EX resolves the oldest in-flight branch, the unit compares the actual outcome with the record and produces a registered one-cycle mispredict/flush pulse. That pulse carries the corrected PC and the repaired global history. It also keeps saturating branch and mispredict performance counters.

---
 rtl/branch_resolution_unit.sv | 134 +++++++++++++
 tb/tb_branch_resolution_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: in-order queue of IF predictions checked against EX
// outcomes, producing a registered flush/redirect pulse and perf counters.
module branch_resolution_unit #(
    parameter int DEPTH      = 4,
    parameter int GBHR_WIDTH = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  IF_push,
    input  logic                  IF_pred_taken,
    input  logic [31:0]           IF_pred_target,
    input  logic [31:0]           IF_fallthrough,
    input  logic [GBHR_WIDTH-1:0] IF_gbhr,
    input  logic                  EX_resolve,
    input  logic                  EX_br_en,
    input  logic [31:0]           EX_target,
    output logic                  mispredict,
    output logic [31:0]           redirect_pc,
    output logic [GBHR_WIDTH-1:0] restore_gbhr,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0]      taken_q;
    logic [31:0]           tgt_q   [DEPTH];
    logic [31:0]           ft_q    [DEPTH];
    logic [GBHR_WIDTH-1:0] gbhr_q  [DEPTH];

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  misp_q, misp_d;
    logic [31:0]           rpc_q, rpc_d;
    logic [GBHR_WIDTH-1:0] rg_q, rg_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic [CNT_WIDTH-1:0]  bc_q, bc_d, mc_q, mc_d;

    logic push, res, is_full, is_empty, pop, wrong, flush, do_push;

    assign push     = IF_push & ~stall;
    assign res      = EX_resolve & ~stall;
    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);
    assign pop      = res & ~is_empty;

    // Target only matters when both predicted and actual are taken
    assign wrong = (taken_q[head_q] != EX_br_en)
                 | (taken_q[head_q] & EX_br_en & (tgt_q[head_q] != EX_target));
    assign flush   = pop & wrong;
    assign do_push = push & ~flush & (~is_full | pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (pop)     head_d = head_q + 1'b1;
            if (do_push) tail_d = tail_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(pop);
        end
    end

    always_comb begin
        misp_d = flush;
        rpc_d  = rpc_q;
        rg_d   = rg_q;
        if (flush) begin
            rpc_d = EX_br_en ? EX_target : ft_q[head_q];
            rg_d  = {gbhr_q[head_q][GBHR_WIDTH-2:0], EX_br_en};
        end
        bc_d  = (pop && !(&bc_q)) ? bc_q + 1'b1 : bc_q;
        mc_d  = (flush && !(&mc_q)) ? mc_q + 1'b1 : mc_q;
        ovf_d = ovf_q | (push & is_full & ~pop);
        unf_d = unf_q | (res & is_empty);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            taken_q[tail_q] <= IF_pred_taken;
            tgt_q[tail_q]   <= IF_pred_target;
            ft_q[tail_q]    <= IF_fallthrough;
            gbhr_q[tail_q]  <= IF_gbhr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            misp_q  <= 1'b0;
            rpc_q   <= '0;
            rg_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            bc_q    <= '0;
            mc_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            misp_q  <= misp_d;
            rpc_q   <= rpc_d;
            rg_q    <= rg_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            bc_q    <= bc_d;
            mc_q    <= mc_d;
        end
    end

    assign mispredict       = misp_q;
    assign redirect_pc      = rpc_q;
    assign restore_gbhr     = rg_q;
    assign full             = is_full;
    assign empty            = is_empty;
    assign overflow         = ovf_q;
    assign underflow        = unf_q;
    assign branch_count     = bc_q;
    assign mispredict_count = mc_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_branch_resolution_unit;

    localparam int D = 4;
    localparam int G = 3;
    localparam int C = 32;

    logic          clk = 0;
    logic          rst = 1;
    logic          stall = 0;
    logic          IF_push = 0;
    logic          IF_pred_taken = 0;
    logic [31:0]   IF_pred_target = 0;
    logic [31:0]   IF_fallthrough = 0;
    logic [G-1:0]  IF_gbhr = 0;
    logic          EX_resolve = 0;
    logic          EX_br_en = 0;
    logic [31:0]   EX_target = 0;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic [G-1:0]  restore_gbhr;
    logic          full, empty, overflow, underflow;
    logic [C-1:0]  branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_resolution_unit #(.DEPTH(D), .GBHR_WIDTH(G), .CNT_WIDTH(C)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .IF_push(IF_push), .IF_pred_taken(IF_pred_taken),
        .IF_pred_target(IF_pred_target), .IF_fallthrough(IF_fallthrough),
        .IF_gbhr(IF_gbhr), .EX_resolve(EX_resolve), .EX_br_en(EX_br_en),
        .EX_target(EX_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .restore_gbhr(restore_gbhr),
        .full(full), .empty(empty), .overflow(overflow),
        .underflow(underflow), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          t;
        logic [31:0] tg;
        logic [31:0] ft;
        logic [G-1:0] g;
    } rec_t;

    rec_t         mq[$];
    bit           m_misp, m_ovf, m_unf;
    logic [31:0]  m_rpc;
    logic [G-1:0] m_rg;
    longint       m_bc, m_mc;

    // Reference: apply the rules for one clock edge using current inputs
    task automatic model_edge();
        bit p, r, w;
        rec_t h, n;
        m_misp = 0;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_rpc = 0; m_rg = 0; m_bc = 0; m_mc = 0;
            return;
        end
        p = IF_push && !stall;
        r = EX_resolve && !stall;
        if (r) begin
            if (mq.size() == 0) m_unf = 1;
            else begin
                h = mq.pop_front();
                if (m_bc < 64'hFFFF_FFFF) m_bc++;
                w = (h.t != EX_br_en) || (h.t && EX_br_en && h.tg != EX_target);
                if (w) begin
                    if (m_mc < 64'hFFFF_FFFF) m_mc++;
                    m_misp = 1;
                    m_rpc = EX_br_en ? EX_target : h.ft;
                    m_rg = {h.g[G-2:0], EX_br_en};
                    mq.delete();
                    p = 0;
                end
            end
        end
        if (p) begin
            if (mq.size() < D) begin
                n.t = IF_pred_taken; n.tg = IF_pred_target;
                n.ft = IF_fallthrough; n.g = IF_gbhr;
                mq.push_back(n);
            end else m_ovf = 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; IF_push = 0; EX_resolve = 0;
    endtask

    task automatic set_push(bit t, logic [31:0] tg, logic [31:0] ft, logic [G-1:0] g);
        IF_push = 1; IF_pred_taken = t; IF_pred_target = tg;
        IF_fallthrough = ft; IF_gbhr = g;
    endtask

    task automatic set_res(bit b, logic [31:0] tg);
        EX_resolve = 1; EX_br_en = b; EX_target = tg;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; IF_push = 1; EX_resolve = 1; EX_br_en = 1;
        step();
        step();
        idle_inputs();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_empty_full got e=%b f=%b exp e=1 f=0", empty, full);
        end
        checks++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h0 || restore_gbhr !== 3'b000) begin
            errors++;
            $display("FAIL reset_misp got m=%b pc=%h g=%b exp 0", mispredict, redirect_pc, restore_gbhr);
        end
        checks++;
        if (branch_count !== 0 || mispredict_count !== 0 || overflow !== 0 || underflow !== 0) begin
            errors++;
            $display("FAIL reset_cnt got bc=%0d mc=%0d o=%b u=%b exp 0", branch_count,
                     mispredict_count, overflow, underflow);
        end
    endtask

    task automatic test_correct();
        do_reset();
        set_push(1, 32'h100, 32'h54, 3'b101);
        step();
        idle_inputs();
        step();
        set_res(1, 32'h100);
        step();
        idle_inputs();
        checks++;
        if (mispredict !== 1'b0 || branch_count !== 1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL correct got m=%b bc=%0d e=%b exp m=0 bc=1 e=1", mispredict,
                     branch_count, empty);
        end
    endtask

    task automatic test_direction();
        do_reset();
        set_push(0, 32'h40, 32'h24, 3'b011);
        step();
        set_push(1, 32'h300, 32'h2c, 3'b110);
        step();
        set_push(0, 32'h400, 32'h34, 3'b100);
        step();
        idle_inputs();
        set_res(1, 32'h80);
        set_push(1, 32'h500, 32'h60, 3'b001);
        step();
        idle_inputs();
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h80 || restore_gbhr !== 3'b111) begin
            errors++;
            $display("FAIL dir_misp got m=%b pc=%h g=%b exp m=1 pc=80 g=111", mispredict,
                     redirect_pc, restore_gbhr);
        end
        checks++;
        if (empty !== 1'b1 || mispredict_count !== 1 || branch_count !== 1) begin
            errors++;
            $display("FAIL dir_flush got e=%b mc=%0d bc=%0d exp 1 1 1", empty,
                     mispredict_count, branch_count);
        end
        // push during the pulse is the first correct-path branch
        set_push(1, 32'h700, 32'h84, 3'b010);
        step();
        idle_inputs();
        checks++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h80 || empty !== 1'b0) begin
            errors++;
            $display("FAIL dir_after got m=%b pc=%h e=%b exp m=0 pc=80 e=0", mispredict,
                     redirect_pc, empty);
        end
    endtask

    task automatic test_target();
        do_reset();
        set_push(1, 32'h200, 32'h10, 3'b010);
        step();
        idle_inputs();
        set_res(1, 32'h204);
        step();
        idle_inputs();
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h204 || restore_gbhr !== 3'b101) begin
            errors++;
            $display("FAIL target got m=%b pc=%h g=%b exp m=1 pc=204 g=101", mispredict,
                     redirect_pc, restore_gbhr);
        end
        // predicted taken, actually not taken: redirect to fall-through
        set_push(1, 32'h300, 32'h88, 3'b001);
        step();
        idle_inputs();
        set_res(0, 32'h300);
        step();
        idle_inputs();
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h88 || restore_gbhr !== 3'b010) begin
            errors++;
            $display("FAIL nt_ft got m=%b pc=%h g=%b exp m=1 pc=88 g=010", mispredict,
                     redirect_pc, restore_gbhr);
        end
    endtask

    task automatic test_full_wrap();
        int bad = 0;
        do_reset();
        for (int i = 0; i <= D; i++) begin
            set_push(i[0], 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 4), 3'(i));
            step();
        end
        idle_inputs();
        checks++;
        if (overflow !== 1'b1 || full !== 1'b1 || mq.size() != D) begin
            errors++;
            $display("FAIL full_ovf got o=%b f=%b exp o=1 f=1", overflow, full);
        end
        for (int i = 0; i < 2 * D; i++) begin
            set_push($urandom_range(0, 1), 32'h3000 + 32'(i * 8), 32'h4000 + 32'(i * 4), 3'($urandom));
            set_res(mq[0].t, mq[0].tg);
            step();
            if (mispredict !== 1'b0 || full !== 1'b1) bad++;
        end
        idle_inputs();
        checks++;
        if (bad != 0 || branch_count !== 2 * D || mispredict_count !== 0) begin
            errors++;
            $display("FAIL wrap_order got bad=%0d bc=%0d mc=%0d exp 0 %0d 0", bad,
                     branch_count, mispredict_count, 2 * D);
        end
    endtask

    task automatic test_stall_underflow();
        do_reset();
        stall = 1;
        set_push(1, 32'h10, 32'h14, 3'b001);
        set_res(0, 32'h0);
        step();
        step();
        checks++;
        if (empty !== 1'b1 || underflow !== 1'b0 || overflow !== 1'b0 || branch_count !== 0) begin
            errors++;
            $display("FAIL stall got e=%b u=%b o=%b bc=%0d exp 1 0 0 0", empty, underflow,
                     overflow, branch_count);
        end
        idle_inputs();
        set_res(1, 32'h20);
        step();
        idle_inputs();
        checks++;
        if (underflow !== 1'b1 || mispredict !== 1'b0 || branch_count !== 0 ||
            mispredict_count !== 0) begin
            errors++;
            $display("FAIL underflow got u=%b m=%b bc=%0d mc=%0d exp 1 0 0 0", underflow,
                     mispredict, branch_count, mispredict_count);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            IF_push = $urandom_range(0, 1);
            IF_pred_taken = $urandom_range(0, 1);
            IF_pred_target = {24'h0, 6'($urandom), 2'b00};
            IF_fallthrough = $urandom;
            IF_gbhr = 3'($urandom);
            EX_resolve = ($urandom_range(0, 2) != 0);
            if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
                EX_br_en = mq[0].t;
                EX_target = mq[0].tg;
            end else begin
                EX_br_en = $urandom_range(0, 1);
                EX_target = {24'h0, 6'($urandom), 2'b00};
            end
            step();
            if (mispredict !== m_misp || redirect_pc !== m_rpc || restore_gbhr !== m_rg ||
                full !== (mq.size() == D) || empty !== (mq.size() == 0) ||
                overflow !== m_ovf || underflow !== m_unf ||
                branch_count !== C'(m_bc) || mispredict_count !== C'(m_mc)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL random cyc=%0d got m=%b pc=%h g=%b bc=%0d mc=%0d exp m=%b pc=%h g=%b bc=%0d mc=%0d",
                             i, mispredict, redirect_pc, restore_gbhr, branch_count,
                             mispredict_count, m_misp, m_rpc, m_rg, m_bc, m_mc);
            end
        end
        idle_inputs();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_total got %0d bad cycles exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_direction();
        test_target();
        test_full_wrap();
        test_stall_underflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
